// File: rtl/pcie_tlp_pkg.sv
// rtl/pcie_tlp_pkg.sv - TLP kind enum, DW0 fmt/type codes, stream beat type and decode helpers
package pcie_tlp_pkg;

  localparam int TLP_DATA_W = 64;
  localparam int TLP_KEEP_W = TLP_DATA_W / 8;

  localparam logic [2:0] FMT_3DW_ND = 3'b000;
  localparam logic [2:0] FMT_4DW_ND = 3'b001;
  localparam logic [2:0] FMT_3DW_D  = 3'b010;
  localparam logic [2:0] FMT_4DW_D  = 3'b011;
  localparam logic [4:0] TYPE_MEM   = 5'b00000;
  localparam logic [4:0] TYPE_CPL   = 5'b01010;

  typedef enum logic [2:0] {OTHER, MRD, MWR, CPL, CPLD} tlp_kind_e;

  typedef struct packed {
    logic [TLP_DATA_W-1:0] data;
    logic [TLP_KEEP_W-1:0] keep;
    logic                  sop;
    logic                  eop;
  } stream_beat_t;

  // byte0 is DW0[31:24]: fmt in [7:5], type in [4:0]
  function automatic tlp_kind_e decode_kind(input logic [7:0] byte0);
    logic [2:0] fmt;
    logic [4:0] typ;
    fmt = byte0[7:5];
    typ = byte0[4:0];
    decode_kind = OTHER;
    if (typ == TYPE_MEM && (fmt == FMT_3DW_ND || fmt == FMT_4DW_ND)) decode_kind = MRD;
    else if (typ == TYPE_MEM && (fmt == FMT_3DW_D || fmt == FMT_4DW_D)) decode_kind = MWR;
    else if (typ == TYPE_CPL && fmt == FMT_3DW_ND) decode_kind = CPL;
    else if (typ == TYPE_CPL && fmt == FMT_3DW_D) decode_kind = CPLD;
  endfunction

  function automatic logic [15:0] keep_dws(input logic [TLP_KEEP_W-1:0] keep);
    int n;
    n = 0;
    for (int i = 0; i < TLP_KEEP_W; i++) begin
      if (keep[i]) n++;
    end
    return 16'(n >> 2);
  endfunction

  function automatic logic [15:0] tlp_expected_dws(input logic [31:0] dw0);
    logic [15:0] pay;
    pay = (dw0[9:0] == 10'd0) ? 16'd1024 : {6'd0, dw0[9:0]};
    return (dw0[29] ? 16'd4 : 16'd3) + (dw0[30] ? pay : 16'd0);
  endfunction

endpackage

// File: rtl/ingress_tlp_router_if.sv
// rtl/ingress_tlp_router_if.sv - framed TLP stream (tdata/tkeep/sop/eop/tvalid/tready) with packet kind
interface ingress_tlp_router_if;
  import pcie_tlp_pkg::*;

  logic                  tready;
  logic [TLP_DATA_W-1:0] tdata;
  logic [TLP_KEEP_W-1:0] tkeep;
  logic                  sop;
  logic                  eop;
  logic                  tvalid;
  tlp_kind_e             kind;

  // kind is only meaningful on router outputs, so the consumer side omits it
  modport master (output tdata, tkeep, sop, eop, tvalid, kind, input tready);
  modport slave  (input tdata, tkeep, sop, eop, tvalid, output tready);

endinterface

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry registered skid carrying a stream beat plus its TLP kind
module axis_skid_buf import pcie_tlp_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  stream_beat_t in_beat,
  input  tlp_kind_e    in_kind,
  input  logic         in_valid,
  output logic         in_ready,
  output stream_beat_t out_beat,
  output tlp_kind_e    out_kind,
  output logic         out_valid,
  input  logic         out_ready
);

  stream_beat_t skid_beat;
  tlp_kind_e    skid_kind;
  logic         skid_valid;
  logic         main_free;

  // ready is purely registered, so upstream never sees a path from out_ready
  assign in_ready  = !skid_valid;
  assign main_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_beat   <= '0;
      out_kind   <= OTHER;
      out_valid  <= 1'b0;
      skid_beat  <= '0;
      skid_kind  <= OTHER;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        out_beat   <= skid_beat;
        out_kind   <= skid_kind;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_beat <= in_beat;
          out_kind <= in_kind;
        end
      end
    end else if (in_valid && in_ready) begin
      skid_beat  <= in_beat;
      skid_kind  <= in_kind;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/ingress_tlp_router.sv
// rtl/ingress_tlp_router.sv - routes framed TLPs to request/completion ports; optional INGRESS_TLP_ROUTER_LEN_CHECK_EN
module ingress_tlp_router import pcie_tlp_pkg::*; #(
  parameter int DATA_W = TLP_DATA_W,
  parameter int KEEP_W = TLP_KEEP_W,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  ingress_tlp_router_if.slave  s_axis,
  ingress_tlp_router_if.master m_req,
  ingress_tlp_router_if.master m_cpl,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 err_seq
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_CPL, ST_DROP} state_e;

  state_e            state, state_nxt, sop_route, route;
  tlp_kind_e         sop_kind, pkt_kind, beat_kind;
  logic [DATA_W-1:0] in_data;
  logic [KEEP_W-1:0] in_keep;
  stream_beat_t      in_beat, req_beat, cpl_beat;
  logic              in_hs, req_valid, cpl_valid, req_ready, cpl_ready;
  logic              err_now, drop_hit, len_err;

  assign in_data   = s_axis.tdata;
  assign in_keep   = s_axis.tkeep;
  assign in_beat   = '{data: in_data, keep: in_keep, sop: s_axis.sop, eop: s_axis.eop};
  assign sop_kind  = decode_kind(in_data[31:24]);
  assign sop_route = (sop_kind == MRD || sop_kind == MWR) ? ST_REQ :
                     (sop_kind == CPL || sop_kind == CPLD) ? ST_CPL : ST_DROP;
  // a sop beat always starts a new packet, even mid-packet; non-sop beats in IDLE go nowhere
  assign route     = s_axis.sop ? sop_route : state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pkt_kind <= OTHER;
      drop_cnt <= '0;
      err_seq  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_hs && s_axis.sop) pkt_kind <= sop_kind;
      if (drop_hit && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
      err_seq <= err_now || len_err;
    end
  end

  always_comb begin
    state_nxt = state;
    if (in_hs) begin
      if (s_axis.eop)      state_nxt = ST_IDLE;
      else if (s_axis.sop) state_nxt = sop_route;
    end
  end

  always_comb begin
    beat_kind = s_axis.sop ? sop_kind : pkt_kind;
    req_valid = s_axis.tvalid && (route == ST_REQ);
    cpl_valid = s_axis.tvalid && (route == ST_CPL);
    case (route)
      ST_REQ:  s_axis.tready = req_ready;
      ST_CPL:  s_axis.tready = cpl_ready;
      default: s_axis.tready = 1'b1;
    endcase
    in_hs    = s_axis.tvalid && s_axis.tready;
    err_now  = in_hs && (s_axis.sop ? (state != ST_IDLE) : (state == ST_IDLE));
    drop_hit = in_hs && s_axis.sop && (sop_route == ST_DROP);
  end

`ifdef INGRESS_TLP_ROUTER_LEN_CHECK_EN
  logic [15:0] dw_seen, dw_want, dw_total, want_now;

  assign dw_total = (s_axis.sop ? 16'd0 : dw_seen) + keep_dws(in_keep);
  assign want_now = s_axis.sop ? tlp_expected_dws(in_data[31:0]) : dw_want;
  assign len_err  = in_hs && s_axis.eop && (route != ST_IDLE) && (dw_total != want_now);

  always_ff @(posedge clk) begin
    if (rst) begin
      dw_seen <= '0;
      dw_want <= '0;
    end else if (in_hs) begin
      dw_seen <= dw_total;
      dw_want <= want_now;
    end
  end
`else
  assign len_err = 1'b0;
`endif

  axis_skid_buf u_req_skid (
    .clk       (clk),
    .rst       (rst),
    .in_beat   (in_beat),
    .in_kind   (beat_kind),
    .in_valid  (req_valid),
    .in_ready  (req_ready),
    .out_beat  (req_beat),
    .out_kind  (m_req.kind),
    .out_valid (m_req.tvalid),
    .out_ready (m_req.tready)
  );

  axis_skid_buf u_cpl_skid (
    .clk       (clk),
    .rst       (rst),
    .in_beat   (in_beat),
    .in_kind   (beat_kind),
    .in_valid  (cpl_valid),
    .in_ready  (cpl_ready),
    .out_beat  (cpl_beat),
    .out_kind  (m_cpl.kind),
    .out_valid (m_cpl.tvalid),
    .out_ready (m_cpl.tready)
  );

  assign m_req.tdata = req_beat.data;
  assign m_req.tkeep = req_beat.keep;
  assign m_req.sop   = req_beat.sop;
  assign m_req.eop   = req_beat.eop;
  assign m_cpl.tdata = cpl_beat.data;
  assign m_cpl.tkeep = cpl_beat.keep;
  assign m_cpl.sop   = cpl_beat.sop;
  assign m_cpl.eop   = cpl_beat.eop;

endmodule

// File: tb/tb_ingress_tlp_router.sv
// tb/tb_ingress_tlp_router.sv - directed and randomized checks of ingress_tlp_router against a packet-level model
module tb_ingress_tlp_router;
  import pcie_tlp_pkg::*;

  typedef logic [76:0] beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] drop_cnt;
  logic        err_seq;

  always #5 clk = ~clk;

  ingress_tlp_router_if s_axis ();
  ingress_tlp_router_if m_req ();
  ingress_tlp_router_if m_cpl ();

  ingress_tlp_router dut (
    .clk      (clk),
    .rst      (rst),
    .s_axis   (s_axis),
    .m_req    (m_req),
    .m_cpl    (m_cpl),
    .drop_cnt (drop_cnt),
    .err_seq  (err_seq)
  );

  int        n_checks = 0;
  int        n_fails  = 0;
  beat_t     exp_q[2][$];
  int        exp_drop;
  logic      in_pkt;
  int        cur_dest;
  tlp_kind_e cur_kind;
  int        stalls = 0;
  bit        bp_en  = 1'b0;
  beat_t     prev_beat[2];
  logic      prev_stall[2];
  logic [7:0] hdrs[9];

  task automatic check(input string tag, input beat_t got, input beat_t want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic tlp_kind_e classify(input logic [31:0] dw0);
    logic [2:0] f;
    logic [4:0] t;
    f = dw0[31:29];
    t = dw0[28:24];
    if (t == 5'h00 && f <= 3'd1) return MRD;
    if (t == 5'h00 && (f == 3'd2 || f == 3'd3)) return MWR;
    if (t == 5'h0A && f == 3'd0) return CPL;
    if (t == 5'h0A && f == 3'd2) return CPLD;
    return OTHER;
  endfunction

  function automatic int dest_of(input tlp_kind_e k);
    if (k == MRD || k == MWR) return 0;
    if (k == CPL || k == CPLD) return 1;
    return 2;
  endfunction

  task automatic model_beat(input logic [63:0] d, input logic [7:0] k,
                            input logic sop, input logic eop, output logic err);
    err = 1'b0;
    if (sop) begin
      err      = in_pkt;
      cur_kind = classify(d[31:0]);
      cur_dest = dest_of(cur_kind);
      if (cur_dest == 2) exp_drop++;
      if (cur_dest < 2) exp_q[cur_dest].push_back({cur_kind, sop, eop, k, d});
      in_pkt = !eop;
    end else if (!in_pkt) begin
      err = 1'b1;
    end else begin
      if (cur_dest < 2) exp_q[cur_dest].push_back({cur_kind, sop, eop, k, d});
      in_pkt = !eop;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #2;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic sop, input logic eop);
    logic hs, e;
    hs = 1'b0;
    s_axis.tdata  = d;
    s_axis.tkeep  = k;
    s_axis.sop    = sop;
    s_axis.eop    = eop;
    s_axis.tvalid = 1'b1;
    for (int i = 0; i < 300 && !hs; i++) begin
      @(negedge clk);
      hs = s_axis.tready;
      if (!hs) stalls++;
      @(posedge clk);
    end
    #2;
    s_axis.tvalid = 1'b0;
    check("in_handshake", hs, 1);
    if (hs) begin
      model_beat(d, k, sop, eop, e);
      check("err_seq", err_seq, e);
    end
  endtask

  task automatic send_pkt(input logic [31:0] dw0, input int nbeats, input int gap, input bit trunc);
    logic [63:0] d;
    logic        last;
    for (int i = 0; i < nbeats; i++) begin
      d    = {$urandom, $urandom};
      last = (i == nbeats - 1);
      if (i == 0) d[31:0] = dw0;
      send_beat(d, last ? 8'($urandom_range(1, 255)) : 8'hff, i == 0, last && !trunc);
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis.tvalid = 1'b0;
    @(posedge clk);
    #2;
    check("rst_req_valid", m_req.tvalid, 0);
    check("rst_cpl_valid", m_cpl.tvalid, 0);
    check("rst_req_data", m_req.tdata, 0);
    check("rst_cpl_data", m_cpl.tdata, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_err_seq", err_seq, 0);
    rst = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    in_pkt   = 1'b0;
    exp_drop = 0;
  endtask

  task automatic mon_port(input int p, input logic v, input logic r, input beat_t b);
    if (prev_stall[p]) begin
      check(p ? "cpl_hold_valid" : "req_hold_valid", v, 1);
      check(p ? "cpl_hold_data" : "req_hold_data", b, prev_beat[p]);
    end
    if (v && r) begin
      check(p ? "cpl_expected" : "req_expected", beat_t'(exp_q[p].size() != 0), 1);
      if (exp_q[p].size() != 0) check(p ? "cpl_beat" : "req_beat", b, exp_q[p].pop_front());
    end
    prev_stall[p] = v && !r;
    prev_beat[p]  = b;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall[0] = 1'b0;
        prev_stall[1] = 1'b0;
      end else begin
        mon_port(0, m_req.tvalid, m_req.tready, {m_req.kind, m_req.sop, m_req.eop, m_req.tkeep, m_req.tdata});
        mon_port(1, m_cpl.tvalid, m_cpl.tready, {m_cpl.kind, m_cpl.sop, m_cpl.eop, m_cpl.tkeep, m_cpl.tdata});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        m_req.tready = ($urandom_range(0, 3) != 0);
        m_cpl.tready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    logic [31:0] dw0;
    hdrs = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h0A, 8'h4A, 8'h30, 8'h04, 8'h00};
    rst           = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.sop    = 1'b0;
    s_axis.eop    = 1'b0;
    s_axis.kind   = OTHER;
    m_req.tready  = 1'b1;
    m_cpl.tready  = 1'b1;
    prev_stall[0] = 1'b0;
    prev_stall[1] = 1'b0;
    do_reset();

    send_beat({32'h1111_2222, 32'h4000_0001}, 8'hff, 1'b1, 1'b0);
    check("mwr_latency_valid", m_req.tvalid, 1);
    check("mwr_kind", m_req.kind, MWR);
    check("mwr_cpl_quiet", m_cpl.tvalid, 0);
    send_beat({$urandom, $urandom}, 8'hff, 1'b0, 1'b1);
    idle(3);
    check("mwr_cpl_still_quiet", m_cpl.tvalid, 0);

    send_beat({32'h0, 32'h4A00_0001}, 8'hff, 1'b1, 1'b1);
    check("cpld_latency_valid", m_cpl.tvalid, 1);
    check("cpld_kind", m_cpl.kind, CPLD);
    check("cpld_drop_cnt", drop_cnt, exp_drop);
    idle(2);

    s0 = stalls;
    send_pkt(32'h3000_0000, 3, 0, 1'b0);
    check("msg_never_stalls", stalls - s0, 0);
    idle(2);
    check("msg_drop_cnt", drop_cnt, exp_drop);

    send_beat({$urandom, $urandom}, 8'hff, 1'b0, 1'b1);
    idle(1);
    check("stray_drop_cnt", drop_cnt, exp_drop);

    s0 = stalls;
    fork
      send_pkt(32'h0000_0008, 6, 0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 m_req.tready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_req.tready = 1'b1;
      end
    join
    check("mrd_backpressure_seen", beat_t'(stalls > s0), 1);
    idle(4);

    send_beat({$urandom, 32'h4000_0004}, 8'hff, 1'b1, 1'b0);
    send_beat({$urandom, $urandom}, 8'hff, 1'b0, 1'b0);
    send_beat({$urandom, 32'h4A00_0002}, 8'hff, 1'b1, 1'b0);
    send_beat({$urandom, $urandom}, 8'hff, 1'b0, 1'b1);
    idle(3);

    m_cpl.tready = 1'b0;
    send_beat({$urandom, 32'h4A00_0003}, 8'hff, 1'b1, 1'b0);
    do_reset();
    m_cpl.tready = 1'b1;
    send_pkt(32'h2000_0002, 2, 0, 1'b0);
    idle(3);

    bp_en = 1'b1;
    for (int p = 0; p < 60; p++) begin
      dw0 = {hdrs[$urandom_range(0, 8)], 24'($urandom)};
      if ($urandom_range(0, 8) == 0) dw0[31:24] = 8'($urandom);
      if ($urandom_range(0, 9) == 0) send_beat({$urandom, $urandom}, 8'hff, 1'b0, 1'($urandom_range(0, 1)));
      send_pkt(dw0, $urandom_range(1, 5), 2, $urandom_range(0, 12) == 0);
    end
    send_pkt(32'h4000_0001, 2, 0, 1'b0);
    bp_en = 1'b0;
    m_req.tready = 1'b1;
    m_cpl.tready = 1'b1;
    for (int i = 0; i < 200 && (exp_q[0].size() + exp_q[1].size()) != 0; i++) @(posedge clk);
    idle(2);
    check("req_drained", exp_q[0].size(), 0);
    check("cpl_drained", exp_q[1].size(), 0);
    check("final_drop_cnt", drop_cnt, exp_drop);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
